// File: rtl/cvt12_cxu.sv
// L2-to-L1 CXU adapter: forwards requests to a fixed-latency L1 CXU and buffers its
// responses in a FIFO sized to the outstanding-request budget, so upstream stalls never drop data.

module cvt12_cxu_chk #(
    parameter int CNT_W = 1
) (
    input logic             clk,
    input logic             rst,
    input logic             push,
    input logic             pop,
    input logic             full,
    input logic [CNT_W-1:0] cnt,
    input logic [CNT_W-1:0] depth
);
    // The credit counter guarantees a full FIFO only ever receives data alongside a pop.
    no_overflow_a: assert property (@(posedge clk) disable iff (!rst) !(push && full && !pop));
    cnt_bound_a:   assert property (@(posedge clk) disable iff (!rst) cnt <= depth);
endmodule

module cvt12_cxu #(
    parameter int CXU_LATENCY    = 0,
    parameter int CXU_FUNC_ID_W  = 10,
    parameter int CXU_DATA_W     = 32,
    parameter int CXU_CXU_ID_W   = 4,
    parameter int CXU_STATE_ID_W = 4,
    parameter int CXU_STATUS_W   = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      clk_en,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic [CXU_CXU_ID_W-1:0]   req_cxu,
    input  logic [CXU_STATE_ID_W-1:0] req_state,
    input  logic [CXU_FUNC_ID_W-1:0]  req_func,
    input  logic [CXU_DATA_W-1:0]     req_data0,
    input  logic [CXU_DATA_W-1:0]     req_data1,
    output logic                      resp_valid,
    input  logic                      resp_ready,
    output logic [CXU_STATUS_W-1:0]   resp_status,
    output logic [CXU_DATA_W-1:0]     resp_data,
    output logic                      t_req_valid,
    output logic [CXU_CXU_ID_W-1:0]   t_req_cxu,
    output logic [CXU_STATE_ID_W-1:0] t_req_state,
    output logic [CXU_FUNC_ID_W-1:0]  t_req_func,
    output logic [CXU_DATA_W-1:0]     t_req_data0,
    output logic [CXU_DATA_W-1:0]     t_req_data1,
    input  logic                      t_resp_valid,
    input  logic [CXU_STATUS_W-1:0]   t_resp_status,
    input  logic [CXU_DATA_W-1:0]     t_resp_data
);
    localparam int DEPTH = CXU_LATENCY + 1;
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int ENT_W = CXU_STATUS_W + CXU_DATA_W;
    localparam logic [CNT_W-1:0] DEPTH_C  = CNT_W'(DEPTH);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);

    // Pointers wrap modulo DEPTH, which need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        if (ptr == PTR_LAST) begin
            ptr_inc = {PTR_W{1'b0}};
        end else begin
            ptr_inc = ptr + PTR_W'(1);
        end
    endfunction

    logic [ENT_W-1:0] fifo_mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_nxt_s;
    logic [CNT_W-1:0] occ_r;
    logic [CNT_W-1:0] occ_nxt_s;
    logic             empty_s;
    logic             full_s;
    logic             pop_s;
    logic             push_s;
    logic             accept_s;
    logic [ENT_W-1:0] head_s;

    assign empty_s    = (occ_r == {CNT_W{1'b0}});
    assign full_s     = (occ_r == DEPTH_C);
    assign resp_valid = !empty_s && clk_en;
    assign pop_s      = resp_valid && resp_ready && clk_en;
    // A slot freed by this cycle's pop can be re-issued immediately.
    assign req_ready  = clk_en && ((cnt_r < DEPTH_C) || pop_s);
    assign accept_s   = req_valid && req_ready;
    assign push_s     = t_resp_valid && clk_en;

    assign t_req_valid = accept_s;
    assign t_req_cxu   = req_cxu;
    assign t_req_state = req_state;
    assign t_req_func  = req_func;
    assign t_req_data0 = req_data0;
    assign t_req_data1 = req_data1;

    assign head_s      = fifo_mem_r[rd_ptr_r];
    assign resp_status = head_s[ENT_W-1:CXU_DATA_W];
    assign resp_data   = head_s[CXU_DATA_W-1:0];

    // Outstanding-request credit and FIFO occupancy next-state.
    always_comb begin
        cnt_nxt_s = cnt_r;
        occ_nxt_s = occ_r;
        case ({accept_s, pop_s})
            2'b10:   cnt_nxt_s = cnt_r + CNT_W'(1);
            2'b01:   cnt_nxt_s = cnt_r - CNT_W'(1);
            default: cnt_nxt_s = cnt_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   occ_nxt_s = occ_r + CNT_W'(1);
            2'b01:   occ_nxt_s = occ_r - CNT_W'(1);
            default: occ_nxt_s = occ_r;
        endcase
    end

    // Control state; clk_en gating lives in accept/push/pop so a disabled cycle changes nothing.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt_r    <= {CNT_W{1'b0}};
            occ_r    <= {CNT_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else begin
            cnt_r    <= cnt_nxt_s;
            occ_r    <= occ_nxt_s;
            rd_ptr_r <= pop_s ? ptr_inc(rd_ptr_r) : rd_ptr_r;
            wr_ptr_r <= push_s ? ptr_inc(wr_ptr_r) : wr_ptr_r;
        end
    end

    // Response storage; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (push_s) begin
            fifo_mem_r[wr_ptr_r] <= {t_resp_status, t_resp_data};
        end
    end

    cvt12_cxu_chk #(.CNT_W(CNT_W)) u_chk (
        .clk   (clk),
        .rst   (rst),
        .push  (push_s),
        .pop   (pop_s),
        .full  (full_s),
        .cnt   (cnt_r),
        .depth (DEPTH_C)
    );
endmodule

// File: tb/tb_cvt12_cxu.sv
// Bench for cvt12_cxu: four instances (latency 0..3) each fed by a fixed-latency adder
// subordinate, compared cycle by cycle against a queue-based model of requests in flight.

module tb_cvt12_cxu;
    localparam int NI = 4;

    typedef struct {
        int          t;
        logic [34:0] v;
    } pend_t;

    logic clk = 1'b0;
    logic rst, clk_en, req_valid, resp_ready;
    logic [3:0]  req_cxu, req_state;
    logic [9:0]  req_func;
    logic [31:0] req_data0, req_data1;
    logic [NI-1:0]        req_ready, resp_valid, t_req_valid, t_resp_valid;
    logic [NI-1:0][2:0]   resp_status, t_resp_status;
    logic [NI-1:0][31:0]  resp_data, t_req_data0, t_req_data1, t_resp_data;
    logic [NI-1:0][3:0]   t_req_cxu, t_req_state;
    logic [NI-1:0][9:0]   t_req_func;

    int    checks = 0;
    int    failures = 0;
    pend_t q[$];
    int    ecyc;
    int    cur;
    logic  obs_rv, obs_rdy;
    logic [31:0] obs_rdata;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_inst
        logic [34:0] sub_in_s;
        logic        sub_v_s;
        logic [34:0] sub_d_s;
        assign sub_in_s = {t_req_func[g][2:0], t_req_data0[g] + t_req_data1[g]};
        if (g == 0) begin : g_comb
            assign sub_v_s = t_req_valid[g];
            assign sub_d_s = sub_in_s;
        end else begin : g_pipe
            logic [g-1:0] pv_r;
            logic [34:0]  pd_r [g];
            // Fixed-latency adder standing in for the L1 CXU; it shares the clock enable.
            always @(posedge clk or negedge rst) begin
                if (!rst) begin
                    pv_r <= '0;
                end else if (clk_en) begin
                    pv_r[0] <= t_req_valid[g];
                    pd_r[0] <= sub_in_s;
                    for (int i = 1; i < g; i++) begin
                        pv_r[i] <= pv_r[i-1];
                        pd_r[i] <= pd_r[i-1];
                    end
                end
            end
            assign sub_v_s = pv_r[g-1];
            assign sub_d_s = pd_r[g-1];
        end
        assign t_resp_valid[g]  = sub_v_s;
        assign t_resp_status[g] = sub_d_s[34:32];
        assign t_resp_data[g]   = sub_d_s[31:0];

        cvt12_cxu #(.CXU_LATENCY(g)) u_dut (
            .clk(clk), .rst(rst), .clk_en(clk_en),
            .req_valid(req_valid), .req_ready(req_ready[g]),
            .req_cxu(req_cxu), .req_state(req_state), .req_func(req_func),
            .req_data0(req_data0), .req_data1(req_data1),
            .resp_valid(resp_valid[g]), .resp_ready(resp_ready),
            .resp_status(resp_status[g]), .resp_data(resp_data[g]),
            .t_req_valid(t_req_valid[g]), .t_req_cxu(t_req_cxu[g]),
            .t_req_state(t_req_state[g]), .t_req_func(t_req_func[g]),
            .t_req_data0(t_req_data0[g]), .t_req_data1(t_req_data1[g]),
            .t_resp_valid(t_resp_valid[g]), .t_resp_status(t_resp_status[g]),
            .t_resp_data(t_resp_data[g])
        );
    end

    // One clock of stimulus on instance cur; the model tracks every request accepted and not yet
    // popped, tagged with the enabled cycle from which its response may first be seen.
    task automatic cycle(input logic v, input logic [31:0] d0, input logic [31:0] d1,
                         input logic rr, input logic ce, output logic acc, output logic pp);
        logic exp_rv, exp_pop, exp_rdy, exp_acc;
        logic [34:0] exp_head;
        req_valid = v; req_data0 = d0; req_data1 = d1;
        req_func = 10'($urandom); req_cxu = 4'($urandom); req_state = 4'($urandom);
        resp_ready = rr; clk_en = ce;
        @(negedge clk);
        exp_rv = 1'b0; exp_head = 35'd0;
        if (ce && q.size() > 0) begin
            if (q[0].t <= ecyc) begin
                exp_rv = 1'b1; exp_head = q[0].v;
            end
        end
        exp_pop = exp_rv && rr;
        exp_rdy = ce && ((q.size() < cur + 1) || exp_pop);
        exp_acc = v && exp_rdy;
        obs_rv = resp_valid[cur]; obs_rdy = req_ready[cur]; obs_rdata = resp_data[cur];
        checks++;
        if (obs_rdy !== exp_rdy) begin
            failures++; $display("FAIL req_ready L=%0d ecyc=%0d: got %b expected %b", cur, ecyc, obs_rdy, exp_rdy);
        end
        checks++;
        if (obs_rv !== exp_rv) begin
            failures++; $display("FAIL resp_valid L=%0d ecyc=%0d: got %b expected %b", cur, ecyc, obs_rv, exp_rv);
        end
        checks++;
        if (t_req_valid[cur] !== exp_acc) begin
            failures++; $display("FAIL t_req_valid L=%0d ecyc=%0d: got %b expected %b", cur, ecyc, t_req_valid[cur], exp_acc);
        end
        if (exp_rv) begin
            checks++;
            if ({resp_status[cur], resp_data[cur]} !== exp_head) begin
                failures++; $display("FAIL resp_payload L=%0d ecyc=%0d: got %h expected %h", cur, ecyc, {resp_status[cur], resp_data[cur]}, exp_head);
            end
        end
        if (exp_acc) begin
            checks++;
            if ({t_req_cxu[cur], t_req_state[cur], t_req_func[cur], t_req_data0[cur], t_req_data1[cur]}
                !== {req_cxu, req_state, req_func, d0, d1}) begin
                failures++; $display("FAIL t_req_passthru L=%0d: got %h expected %h", cur,
                    {t_req_cxu[cur], t_req_state[cur], t_req_func[cur], t_req_data0[cur], t_req_data1[cur]},
                    {req_cxu, req_state, req_func, d0, d1});
            end
        end
        acc = t_req_valid[cur];
        pp  = obs_rv && rr;
        @(posedge clk); #1;
        if (exp_pop) void'(q.pop_front());
        if (exp_acc) q.push_back('{t: ecyc + cur + 1, v: {req_func[2:0], d0 + d1}});
        if (ce) ecyc++;
    endtask

    task automatic do_reset(input int k);
        cur = k; req_valid = 1'b0; resp_ready = 1'b0; clk_en = 1'b1;
        rst = 1'b0;
        #1;
        checks++;
        if (resp_valid[cur] !== 1'b0) begin
            failures++; $display("FAIL reset_resp_valid L=%0d: got %b expected 0", cur, resp_valid[cur]);
        end
        checks++;
        if (req_ready[cur] !== 1'b1) begin
            failures++; $display("FAIL reset_req_ready L=%0d: got %b expected 1", cur, req_ready[cur]);
        end
        q.delete(); ecyc = 0;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_reset();
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
                failures++; $display("FAIL reset_en L=%0d: got rv=%b rdy=%b expected rv=0 rdy=1", k, resp_valid[k], req_ready[k]);
            end
        end
        clk_en = 1'b0; #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (req_ready[k] !== 1'b0) begin
                failures++; $display("FAIL reset_noen_ready L=%0d: got %b expected 0", k, req_ready[k]);
            end
        end
        clk_en = 1'b1;
        @(negedge clk); rst = 1'b1;
        @(posedge clk); #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (resp_valid[k] !== 1'b0 || req_ready[k] !== 1'b1) begin
                failures++; $display("FAIL post_reset L=%0d: got rv=%b rdy=%b expected rv=0 rdy=1", k, resp_valid[k], req_ready[k]);
            end
        end
    endtask

    task automatic test_single();
        logic acc, pp;
        do_reset(0);
        cycle(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, acc, pp);
        checks++;
        if (acc !== 1'b1) begin
            failures++; $display("FAIL single_issue: got t_req_valid=%b expected 1", acc);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc, pp);
        checks++;
        if (pp !== 1'b1 || obs_rdata !== 32'd12) begin
            failures++; $display("FAIL single_resp: got valid=%b data=%0d expected valid=1 data=12", pp, obs_rdata);
        end
        cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc, pp);
        checks++;
        if (obs_rdy !== 1'b1 || obs_rv !== 1'b0) begin
            failures++; $display("FAIL single_drained: got rdy=%b rv=%b expected rdy=1 rv=0", obs_rdy, obs_rv);
        end
    endtask

    task automatic test_back_to_back();
        logic acc, pp;
        int n_acc, n_pop, first_pop, last_pop;
        n_acc = 0; n_pop = 0; first_pop = -1; last_pop = -1;
        do_reset(2);
        for (int i = 0; i < 18; i++) begin
            cycle(i < 10, $urandom, $urandom, 1'b1, 1'b1, acc, pp);
            if (acc) n_acc++;
            if (pp) begin
                n_pop++;
                if (first_pop < 0) first_pop = i;
                last_pop = i;
            end
        end
        checks++;
        if (n_acc != 10) begin
            failures++; $display("FAIL b2b_accepts: got %0d expected 10", n_acc);
        end
        checks++;
        if (first_pop != 3 || last_pop != 12 || n_pop != 10) begin
            failures++; $display("FAIL b2b_resps: got first=%0d last=%0d n=%0d expected 3 12 10", first_pop, last_pop, n_pop);
        end
    endtask

    task automatic test_stall();
        logic acc, pp;
        int n_acc;
        n_acc = 0;
        do_reset(2);
        for (int i = 0; i < 6; i++) begin
            cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, acc, pp);
            if (acc) n_acc++;
        end
        checks++;
        if (n_acc != 3 || obs_rdy !== 1'b0) begin
            failures++; $display("FAIL stall_accepts: got n=%0d rdy=%b expected n=3 rdy=0", n_acc, obs_rdy);
        end
        cycle(1'b1, $urandom, $urandom, 1'b1, 1'b1, acc, pp);
        checks++;
        if (acc !== 1'b1 || pp !== 1'b1) begin
            failures++; $display("FAIL stall_release: got acc=%b pop=%b expected 1 1", acc, pp);
        end
        for (int i = 0; i < 6; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc, pp);
    endtask

    task automatic test_clk_en();
        logic acc, pp;
        int n_acc, n_pop;
        n_acc = 0; n_pop = 0;
        do_reset(1);
        for (int i = 0; i < 19; i++) begin
            cycle(i < 13, $urandom, $urandom, 1'b1, !(i >= 3 && i < 7), acc, pp);
            if (acc) n_acc++;
            if (pp) n_pop++;
            if (i >= 3 && i < 7) begin
                checks++;
                if (obs_rdy !== 1'b0 || obs_rv !== 1'b0) begin
                    failures++; $display("FAIL clk_en_freeze: got rdy=%b rv=%b expected 0 0", obs_rdy, obs_rv);
                end
            end
        end
        checks++;
        if (n_pop != n_acc || n_acc != 9) begin
            failures++; $display("FAIL clk_en_count: got acc=%0d pop=%0d expected 9 9", n_acc, n_pop);
        end
    endtask

    task automatic test_reset_mid();
        logic acc, pp, got;
        do_reset(1);
        cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, acc, pp);
        cycle(1'b1, $urandom, $urandom, 1'b0, 1'b1, acc, pp);
        checks++;
        if (resp_valid[1] !== 1'b1) begin
            failures++; $display("FAIL mid_pre_reset: got resp_valid=%b expected 1", resp_valid[1]);
        end
        do_reset(1);
        cycle(1'b1, 32'd100, 32'd23, 1'b1, 1'b1, acc, pp);
        got = 1'b0;
        for (int i = 0; i < 4; i++) begin
            cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc, pp);
            if (pp && !got) begin
                got = 1'b1;
                checks++;
                if (obs_rdata !== 32'd123) begin
                    failures++; $display("FAIL mid_first_resp: got %0d expected 123", obs_rdata);
                end
            end
        end
        checks++;
        if (!got) begin
            failures++; $display("FAIL mid_no_resp: got none expected one response");
        end
    endtask

    task automatic test_random();
        logic acc, pp;
        int lat;
        for (int li = 0; li < 3; li++) begin
            lat = (li == 0) ? 0 : ((li == 1) ? 1 : 3);
            do_reset(lat);
            for (int i = 0; i < 300; i++) begin
                cycle($urandom_range(99) < 70, $urandom, $urandom,
                      $urandom_range(99) < 60, $urandom_range(99) < 90, acc, pp);
            end
            for (int i = 0; i < 12; i++) cycle(1'b0, 32'd0, 32'd0, 1'b1, 1'b1, acc, pp);
            checks++;
            if (obs_rv !== 1'b0 || obs_rdy !== 1'b1) begin
                failures++; $display("FAIL random_drain L=%0d: got rv=%b rdy=%b expected 0 1", lat, obs_rv, obs_rdy);
            end
        end
    endtask

    initial begin
        rst = 1'b0; clk_en = 1'b1; req_valid = 1'b0; resp_ready = 1'b0;
        req_cxu = 4'd0; req_state = 4'd0; req_func = 10'd0; req_data0 = 32'd0; req_data1 = 32'd0;
        ecyc = 0; cur = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_stall();
        test_clk_en();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/cvt12_cxu.md
CVT12_CXU -- requirements
Module: cvt12_cxu

Interface
REQ-001 SHALL have parameter CXU_LATENCY, default 0, fixed response latency in cycles of the subordinate L1 CXU.
REQ-002 SHALL have parameter CXU_FUNC_ID_W, default 10, function ID width.
REQ-003 SHALL have parameter CXU_DATA_W, default 32, request and response data width.
REQ-004 SHALL have parameters CXU_CXU_ID_W, default 4; CXU_STATE_ID_W, default 4; and CXU_STATUS_W, default 3.
REQ-005 SHALL have port clk, input, 1, the only clock.
REQ-006 SHALL have port rst, input, 1: reset is asynchronous and active-low.
REQ-007 SHALL have port clk_en, input, 1, global clock enable.
REQ-008 SHALL have upstream L2 request ports: req_valid in 1; req_ready out 1; req_cxu in CXU_CXU_ID_W; req_state in CXU_STATE_ID_W; req_func in CXU_FUNC_ID_W; req_data0 in CXU_DATA_W; req_data1 in CXU_DATA_W.
REQ-009 SHALL have upstream L2 response ports: resp_valid out 1; resp_ready in 1; resp_status out CXU_STATUS_W; resp_data out CXU_DATA_W.
REQ-010 SHALL have subordinate L1 request ports: t_req_valid, t_req_cxu, t_req_state, t_req_func, t_req_data0 and t_req_data1, all outputs with the same widths as the req_* inputs.
REQ-011 SHALL have subordinate L1 response ports: t_resp_valid in 1; t_resp_status in CXU_STATUS_W; t_resp_data in CXU_DATA_W.

Function
REQ-012 SHALL define DEPTH = CXU_LATENCY+1 and hold a response FIFO of DEPTH entries, each entry CXU_STATUS_W+CXU_DATA_W bits wide.
REQ-013 SHALL keep an outstanding counter cnt, range 0..DEPTH, counting requests accepted but not yet popped upstream.
REQ-014 SHALL define pop = resp_valid && resp_ready && clk_en.
REQ-015 SHALL drive req_ready = clk_en && (cnt < DEPTH || pop); this is a combinational path from resp_ready and is permitted.
REQ-016 SHALL define accept = req_valid && req_ready.
REQ-017 SHALL drive t_req_valid = accept, and pass t_req_cxu, t_req_state, t_req_func, t_req_data0 and t_req_data1 through combinationally from the req_* inputs.
REQ-018 SHALL update cnt by +1 on accept only, by -1 on pop only, and leave it unchanged on both or neither.
REQ-019 SHALL push {t_resp_status, t_resp_data} into the FIFO when t_resp_valid && clk_en; there SHALL be no bypass, so the entry is visible on resp_* the next cycle.
REQ-020 SHALL drive resp_valid = (FIFO not empty) && clk_en, with resp_status and resp_data taken from the FIFO head.
REQ-021 SHALL support push and pop in the same cycle, including when the FIFO is full, with occupancy unchanged and order preserved.
REQ-022 SHALL use wrap-around read/write pointers of width max(1, clog2(DEPTH)) that wrap modulo DEPTH (non-power-of-2 DEPTH allowed).
REQ-023 SHALL have a minimum request-to-response latency of CXU_LATENCY+1 cycles.
REQ-024 SHALL sustain one request per cycle when resp_ready is held at 1.
REQ-025 SHALL keep responses in strict request order.
REQ-026 SHALL guarantee by construction (cnt <= DEPTH) that no push occurs into a full FIFO without a simultaneous pop; such a push SHALL be a design error covered by an assertion.
REQ-027 SHALL freeze all state while clk_en = 0: no accept, no push, no pop.
REQ-028 SHALL hold stalled responses stable: resp_status and resp_data SHALL NOT change while resp_valid = 1 and resp_ready = 0.

Reset
REQ-029 SHALL, when rst = 0, asynchronously clear cnt, the FIFO pointers and the FIFO occupancy to 0.
REQ-030 SHALL hold resp_valid = 0 during reset and after reset until the first push.
REQ-031 SHALL drive req_ready = clk_en out of reset (cnt = 0).
REQ-032 SHALL, on reset mid-operation, discard all in-flight and queued responses; the subordinate is reset by the same rst.
REQ-033 SHALL NOT require reset on the FIFO data storage.

Verification
REQ-034 SHALL cover: L=0, one request (data0=5, data1=7, adder subordinate), resp_ready=1 -> t_req_valid in cycle 0, resp_valid=1 with resp_data=12 in cycle 1, cnt back to 0.
REQ-035 SHALL cover: L=2, 10 back-to-back requests, resp_ready=1 -> req_ready never deasserts, 10 in-order responses starting cycle 3, one per cycle.
REQ-036 SHALL cover: L=2, resp_ready=0, requests offered every cycle -> exactly 3 accepted, then req_ready=0, FIFO holds 3 stable entries; on resp_ready=1, a pop and an accept occur in the same cycle.
REQ-037 SHALL cover: clk_en=0 for 4 cycles mid-stream -> req_ready=0, resp_valid=0, cnt and FIFO unchanged; resumes with no loss or duplication.
REQ-038 SHALL cover: rst asserted with cnt=2 and FIFO occupancy 1 -> resp_valid=0 immediately, cnt=0, and the first post-reset response matches the first post-reset request.
REQ-039 SHALL run random stimulus with random resp_ready for L in {0,1,3}, checked against a scoreboard for order, data and no overflow.
